traffic_counter: RTL and testbench
==================================

# traffic_counter

Vehicle-detector front end for the intersection controller. Synchronizes and debounces one induction-loop sensor per street and counts vehicle arrivals over a fixed sampling window. Presents the saturated per-window counts as the 4-bit `traffic_Street_0` / `traffic_Street_1` values consumed by the intersection's turn controller. Counts hold stable between window boundaries, so the turn controller can sample them at any time.

## Interface

Parameters:
- `WINDOW_CYCLES`, default 1000: sampling window length in clock cycles; legal range ≥ 2.
- `DEBOUNCE_CYCLES`, default 4: consecutive stable cycles required before the filtered sensor level changes; legal range ≥ 1.

Ports:
- `clock`  input  1  single system clock; all logic on the rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `sensor_Street_0`  input  1  raw asynchronous loop detector, street 0; high while a vehicle is present.
- `sensor_Street_1`  input  1  raw asynchronous loop detector, street 1.
- `traffic_Street_0`  output  4  vehicle count for street 0 from the last completed window; saturates at 15.
- `traffic_Street_1`  output  4  vehicle count for street 1 from the last completed window; saturates at 15.
- `sample_Valid`  output  1  one-cycle pulse when both counts have just been updated.

## Operation

- **Synchronizer:** a 2-flop synchronizer per sensor; both flops reset to 0.
- **Debounce:** per sensor, a filtered level `filt` and a stability counter.
  - When the synchronized input equals `filt`, the counter clears.
  - Otherwise the counter increments. When it reaches `DEBOUNCE_CYCLES`, `filt` takes the new value and the counter clears.
  - `filt` resets to 0.
- **Vehicle event:** a rising edge of `filt` (0→1). Only one event is counted per vehicle regardless of dwell time. A falling edge is not counted.
- **Accumulator:** one 4-bit accumulator per street. On an event it computes `min(acc+1, 15)`; at 15 it stays at 15.
- **Window timer:** counts 0 … `WINDOW_CYCLES-1`, then wraps to 0.
- **Terminal cycle** (timer == `WINDOW_CYCLES-1`):
  - Each output register loads the accumulator plus any event in that same cycle, saturated at 15.
  - Accumulators clear to 0. An event in the terminal cycle is never lost and never double-counted.
- Both streets update on the same edge; the outputs are never skewed relative to each other.
- **Reset, including mid-window:** timer, accumulators, `filt`, debounce counters, synchronizer flops, both counts and `sample_Valid` all go to 0. Partial-window counts are discarded.

## Timing

- **Reset values:** `traffic_Street_0` = 0, `traffic_Street_1` = 0, `sample_Valid` = 0.
- **Sensor-to-event latency:** a raw sensor rise held stable is counted `2 + DEBOUNCE_CYCLES` cycles after the first sampling edge.
- **Count update:** outputs change only on the edge that ends the terminal cycle. `sample_Valid` is high for exactly the one cycle following that edge.
- **First update after reset:** `sample_Valid` first rises exactly `WINDOW_CYCLES` cycles after the first edge with `reset` low, then every `WINDOW_CYCLES` cycles.
- **Glitches:** a sensor pulse or gap shorter than `DEBOUNCE_CYCLES` synchronized cycles has no effect.
- No input handshake. The outputs are registered and may feed the turn controller directly.

## Configuration

- Macro: `TRAFFIC_COUNTER_DEBOUNCE_EN`.
- **Defined:** the debounce filter operates as described above.
- **Undefined:**
  - `filt` is the second synchronizer flop directly, with no debounce counters and `DEBOUNCE_CYCLES` ignored.
  - Latency drops to 2 cycles and every synchronized rising edge counts.
  - All other behaviour is identical.

## Test plan

Bench parameters: `WINDOW_CYCLES`=64, `DEBOUNCE_CYCLES`=4, macro defined unless stated.

- **Reset:** hold `reset` 3 cycles, then release with sensors low → both counts 0, `sample_Valid` 0. First `sample_Valid` pulse comes 64 cycles after release with counts 0/0.
- **Basic count:** 3 clean 10-cycle pulses on street 0 and 1 on street 1 within a window → next pulse reports 3/1. Following empty window reports 0/0.
- **Saturation:** 20 clean pulses on street 0 in one window → count 15, street 1 unaffected. The next window starts again from 0.
- **Glitch rejection:** 3-cycle pulses on street 1 → count 0. Repeat with the macro undefined → each pulse counts once.
- **Boundary event:** time a filtered rise to land in the terminal cycle → it is included in that window's count and absent from the next.
- **Mid-window reset:** accumulate 5 events, then pulse `reset` for 1 cycle → outputs 0. Next `sample_Valid` comes 64 cycles after release, counting only post-reset events.

Source files
------------

// File: rtl/traffic_counter.sv
// Two-street vehicle detector: synchronize, debounce, count rising edges per window.
// Debounce filter is enabled with `define TRAFFIC_COUNTER_DEBOUNCE_EN; otherwise filt = 2nd sync flop.
module traffic_counter #(
    parameter int WINDOW_CYCLES   = 1000,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       sensor_Street_0,
    input  logic       sensor_Street_1,
    output logic [3:0] traffic_Street_0,
    output logic [3:0] traffic_Street_1,
    output logic       sample_Valid
);

    localparam int TIMER_W = (WINDOW_CYCLES > 2) ? $clog2(WINDOW_CYCLES) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(WINDOW_CYCLES - 1);

    // Reject parameterisations the window timer and debounce counter cannot represent.
    if (WINDOW_CYCLES < 2 || DEBOUNCE_CYCLES < 1) begin : g_bad_params
        $error("traffic_counter: WINDOW_CYCLES must be >= 2 and DEBOUNCE_CYCLES >= 1");
    end

    logic [1:0]         sensor_raw;
    logic [1:0]         sync1_q, sync1_d;
    logic [1:0]         sync2_q, sync2_d;
    logic [1:0]         filt;
    logic [1:0]         filt_prev_q, filt_prev_d;
    logic [1:0]         vehicle_event;
    logic [3:0]         acc_q   [2];
    logic [3:0]         acc_d   [2];
    logic [3:0]         acc_inc [2];
    logic [3:0]         count_q [2];
    logic [3:0]         count_d [2];
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               valid_q, valid_d;
    logic               terminal;

    assign sensor_raw    = {sensor_Street_1, sensor_Street_0};
    assign vehicle_event = filt & ~filt_prev_q;
    assign terminal      = (timer_q == TIMER_LAST);

`ifdef TRAFFIC_COUNTER_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       filt_q, filt_d;
    logic [CNT_W-1:0] db_cnt_q [2];
    logic [CNT_W-1:0] db_cnt_d [2];

    // The counter tracks how long the synchronized level has disagreed with filt.
    always_comb begin
        filt_d = filt_q;
        for (int s = 0; s < 2; s++) begin
            db_cnt_d[s] = '0;
            if (sync2_q[s] != filt_q[s]) begin
                if (db_cnt_q[s] == CNT_LAST) begin
                    filt_d[s] = sync2_q[s];
                end else begin
                    db_cnt_d[s] = db_cnt_q[s] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            filt_q <= '0;
            for (int s = 0; s < 2; s++) begin
                db_cnt_q[s] <= '0;
            end
        end else begin
            filt_q <= filt_d;
            for (int s = 0; s < 2; s++) begin
                db_cnt_q[s] <= db_cnt_d[s];
            end
        end
    end

    assign filt = filt_q;
`else
    assign filt = sync2_q;
`endif

    // A terminal-cycle event goes into the outgoing count, never into the fresh accumulator.
    always_comb begin
        sync1_d     = sensor_raw;
        sync2_d     = sync1_q;
        filt_prev_d = filt;
        valid_d     = terminal;
        timer_d     = terminal ? '0 : timer_q + 1'b1;
        for (int s = 0; s < 2; s++) begin
            acc_inc[s] = (acc_q[s] == 4'hF) ? 4'hF : acc_q[s] + {3'b000, vehicle_event[s]};
            acc_d[s]   = acc_inc[s];
            count_d[s] = count_q[s];
            if (terminal) begin
                count_d[s] = acc_inc[s];
                acc_d[s]   = '0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            filt_prev_q <= '0;
            timer_q     <= '0;
            valid_q     <= 1'b0;
            for (int s = 0; s < 2; s++) begin
                acc_q[s]   <= '0;
                count_q[s] <= '0;
            end
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            filt_prev_q <= filt_prev_d;
            timer_q     <= timer_d;
            valid_q     <= valid_d;
            for (int s = 0; s < 2; s++) begin
                acc_q[s]   <= acc_d[s];
                count_q[s] <= count_d[s];
            end
        end
    end

    assign traffic_Street_0 = count_q[0];
    assign traffic_Street_1 = count_q[1];
    assign sample_Valid     = valid_q;

endmodule

// File: tb/tb_traffic_counter.sv
// Bench for traffic_counter: directed scenarios plus random sensor traffic against a window-level model.
// A second instance with a longer window makes 20 debounced pulses fit in one window for saturation.
module tb_traffic_counter;

    localparam int WIN_A = 64;
    localparam int WIN_B = 192;
    localparam int DB    = 4;
`ifdef TRAFFIC_COUNTER_DEBOUNCE_EN
    localparam int LAT       = 2 + DB;
    localparam bit DEBOUNCED = 1'b1;
`else
    localparam int LAT       = 2;
    localparam bit DEBOUNCED = 1'b0;
`endif

    logic       clock;
    logic       reset;
    logic       sensor_Street_0;
    logic       sensor_Street_1;
    logic [3:0] traffic_Street_0;
    logic [3:0] traffic_Street_1;
    logic       sample_Valid;
    logic [3:0] satTraffic0;
    logic [3:0] satTraffic1;
    logic       satValid;

    int checkCount = 0;
    int errorCount = 0;

    traffic_counter #(.WINDOW_CYCLES(WIN_A), .DEBOUNCE_CYCLES(DB)) dut (
        .clock            (clock),
        .reset            (reset),
        .sensor_Street_0  (sensor_Street_0),
        .sensor_Street_1  (sensor_Street_1),
        .traffic_Street_0 (traffic_Street_0),
        .traffic_Street_1 (traffic_Street_1),
        .sample_Valid     (sample_Valid)
    );

    traffic_counter #(.WINDOW_CYCLES(WIN_B), .DEBOUNCE_CYCLES(DB)) dutSat (
        .clock            (clock),
        .reset            (reset),
        .sensor_Street_0  (sensor_Street_0),
        .sensor_Street_1  (sensor_Street_1),
        .traffic_Street_0 (satTraffic0),
        .traffic_Street_1 (satTraffic1),
        .sample_Valid     (satValid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: sensor history -> vehicle events -> per-window event totals.
    bit         mSync1    [2];
    bit         mSync2    [2];
    bit         mFilt     [2];
    bit         mRosePrev [2];
`ifdef TRAFFIC_COUNTER_DEBOUNCE_EN
    bit         mHist     [2][DB];
`endif
    int         mEdges;
    int         mCnt      [2][2];
    logic [3:0] mOut      [2][2];
    bit         mValid    [2];

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s at %0t: observed %0d expected %0d", tag, $time, observed, expected);
        end
    endtask

    function automatic int winOf(input int inst);
        return (inst == 0) ? WIN_A : WIN_B;
    endfunction

    task automatic modelEdge(input bit r0, input bit r1, input bit rst);
        bit raw [2];
        bit newFilt;
        bit allDiff;
        raw[0] = r0;
        raw[1] = r1;
        if (rst) begin
            mEdges = 0;
            for (int s = 0; s < 2; s++) begin
                mSync1[s] = 0; mSync2[s] = 0; mFilt[s] = 0; mRosePrev[s] = 0;
`ifdef TRAFFIC_COUNTER_DEBOUNCE_EN
                for (int k = 0; k < DB; k++) mHist[s][k] = 0;
`endif
            end
            for (int i = 0; i < 2; i++) begin
                mValid[i] = 0;
                for (int s = 0; s < 2; s++) begin
                    mCnt[i][s] = 0; mOut[i][s] = 4'd0;
                end
            end
            return;
        end
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 2; i++) mCnt[i][s] += int'(mRosePrev[s]);
`ifdef TRAFFIC_COUNTER_DEBOUNCE_EN
            // filt flips once the last DB synchronized samples all disagree with it
            for (int k = DB - 1; k > 0; k--) mHist[s][k] = mHist[s][k-1];
            mHist[s][0] = mSync2[s];
            allDiff = 1;
            for (int k = 0; k < DB; k++) if (mHist[s][k] == mFilt[s]) allDiff = 0;
            newFilt = allDiff ? ~mFilt[s] : mFilt[s];
`else
            allDiff = 0;
            newFilt = mSync1[s];
`endif
            mRosePrev[s] = newFilt & ~mFilt[s];
            mFilt[s]     = newFilt;
            mSync2[s]    = mSync1[s];
            mSync1[s]    = raw[s];
        end
        mEdges++;
        for (int i = 0; i < 2; i++) begin
            mValid[i] = (mEdges % winOf(i) == 0);
            if (mValid[i]) begin
                for (int s = 0; s < 2; s++) begin
                    mOut[i][s] = (mCnt[i][s] > 15) ? 4'd15 : 4'(mCnt[i][s]);
                    mCnt[i][s] = 0;
                end
            end
        end
    endtask

    task automatic applyStimulus(input logic s0, input logic s1, input logic rst);
        sensor_Street_0 = s0;
        sensor_Street_1 = s1;
        reset           = rst;
        @(posedge clock);
        modelEdge(s0, s1, rst);
        #1;
        checkOutput("A_valid",  {7'd0, sample_Valid}, {7'd0, mValid[0]});
        checkOutput("A_count0", {4'd0, traffic_Street_0}, {4'd0, mOut[0][0]});
        checkOutput("A_count1", {4'd0, traffic_Street_1}, {4'd0, mOut[0][1]});
        checkOutput("B_valid",  {7'd0, satValid}, {7'd0, mValid[1]});
        checkOutput("B_count0", {4'd0, satTraffic0}, {4'd0, mOut[1][0]});
        checkOutput("B_count1", {4'd0, satTraffic1}, {4'd0, mOut[1][1]});
    endtask

    task automatic runToBoundary(input int inst);
        int n = 0;
        do begin
            applyStimulus(1'b0, 1'b0, 1'b0);
            n++;
        end while (!mValid[inst] && n < 400);
        checkOutput((inst == 0) ? "A_boundary" : "B_boundary",
                    {7'd0, (inst == 0) ? sample_Valid : satValid}, 8'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin
        bit lvl   [2];
        int holdN [2];
        sensor_Street_0 = 1'b0;
        sensor_Street_1 = 1'b0;
        reset           = 1'b1;

        repeat (3) applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("reset_count0", {4'd0, traffic_Street_0}, 8'd0);
        checkOutput("reset_count1", {4'd0, traffic_Street_1}, 8'd0);
        checkOutput("reset_valid",  {7'd0, sample_Valid}, 8'd0);

        for (int i = 1; i <= WIN_A; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0);
            checkOutput("first_valid", {7'd0, sample_Valid}, (i == WIN_A) ? 8'd1 : 8'd0);
        end
        checkOutput("first_count0", {4'd0, traffic_Street_0}, 8'd0);
        checkOutput("first_count1", {4'd0, traffic_Street_1}, 8'd0);

        for (int i = 0; i < 45; i++) applyStimulus((i % 15) < 10, i < 10, 1'b0);
        runToBoundary(0);
        checkOutput("basic_count0", {4'd0, traffic_Street_0}, 8'd3);
        checkOutput("basic_count1", {4'd0, traffic_Street_1}, 8'd1);
        runToBoundary(0);
        checkOutput("empty_count0", {4'd0, traffic_Street_0}, 8'd0);
        checkOutput("empty_count1", {4'd0, traffic_Street_1}, 8'd0);

        if (!mValid[1]) runToBoundary(1);
        for (int p = 0; p < 20; p++)
            for (int c = 0; c < 9; c++) applyStimulus(c < 5, 1'b0, 1'b0);
        runToBoundary(1);
        checkOutput("sat_count0", {4'd0, satTraffic0}, 8'd15);
        checkOutput("sat_count1", {4'd0, satTraffic1}, 8'd0);
        runToBoundary(1);
        checkOutput("sat_next0", {4'd0, satTraffic0}, 8'd0);

        if (!mValid[0]) runToBoundary(0);
        for (int p = 0; p < 5; p++)
            for (int c = 0; c < 8; c++) applyStimulus(1'b0, c < 3, 1'b0);
        runToBoundary(0);
        checkOutput("glitch_count1", {4'd0, traffic_Street_1}, DEBOUNCED ? 8'd0 : 8'd5);

        // Raise street 0 so its event is counted on the edge that closes the window.
        for (int i = 1; i <= WIN_A; i++) applyStimulus(i >= WIN_A - LAT, 1'b0, 1'b0);
        checkOutput("edge_valid",  {7'd0, sample_Valid}, 8'd1);
        checkOutput("edge_count0", {4'd0, traffic_Street_0}, 8'd1);
        repeat (10) applyStimulus(1'b1, 1'b0, 1'b0);
        runToBoundary(0);
        checkOutput("edge_next0", {4'd0, traffic_Street_0}, 8'd0);

        for (int p = 0; p < 5; p++)
            for (int c = 0; c < 10; c++) applyStimulus(c < 5, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("midreset_count0", {4'd0, traffic_Street_0}, 8'd0);
        checkOutput("midreset_valid",  {7'd0, sample_Valid}, 8'd0);
        for (int i = 1; i <= WIN_A; i++) begin
            applyStimulus(1'b0, (((i - 1) % 20) < 10) && (i <= 40), 1'b0);
            checkOutput("post_reset_valid", {7'd0, sample_Valid}, (i == WIN_A) ? 8'd1 : 8'd0);
        end
        checkOutput("post_reset_count0", {4'd0, traffic_Street_0}, 8'd0);
        checkOutput("post_reset_count1", {4'd0, traffic_Street_1}, 8'd2);

        for (int s = 0; s < 2; s++) begin
            lvl[s]   = 0;
            holdN[s] = 0;
        end
        for (int n = 0; n < 800; n++) begin
            for (int s = 0; s < 2; s++) begin
                if (holdN[s] == 0) begin
                    lvl[s]   = ~lvl[s];
                    holdN[s] = $urandom_range(1, 12);
                end
                holdN[s]--;
            end
            applyStimulus(lvl[0], lvl[1], $urandom_range(0, 299) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
